ser_frame_tx: RTL and testbench
===============================

Name: ser_frame_tx

Overview:
- Parallel-to-serial frame transmitter that sits directly upstream of the serial sequence detectors.
- Accepts WIDTH-bit words over a valid/ready handshake and emits them one bit per clock, MSB first.
- Its serial output drives the detector's single-bit `in` input.
- A one-word holding register lets back-to-back words stream with no idle bit between frames.

Parameters:
- WIDTH, 8: bits per word; legal range 2 to 32.
- IDLE_BIT, 0: value driven on out_bit while no frame is being shifted.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-low reset
- data_in  input  WIDTH  parallel word to transmit
- data_valid  input  1  data_in is valid this cycle
- data_ready  output  1  block can accept a word this cycle
- out_bit  output  1  serial bit; connects to the detector's `in`
- out_valid  output  1  out_bit carries frame data this cycle
- frame_done  output  1  high during the last bit of each frame
- busy  output  1  a frame is shifting or a word is held

Behaviour:
- Registers:
  - state: IDLE or SHIFT
  - shift_reg[WIDTH-1:0]
  - bit_cnt: $clog2(WIDTH+1) bits
  - hold_reg[WIDTH-1:0]
  - hold_full
- Reset (reset==0 at a rising edge):
  - state=IDLE, bit_cnt=0, shift_reg=0, hold_reg=0, hold_full=0.
  - Any in-flight or held word is discarded; no frame_done is issued.
- Output values while reset is low or just after reset:
  - data_ready=0 while reset is low; data_ready=1 in the first cycle after reset deasserts.
  - out_valid=0, out_bit=IDLE_BIT, frame_done=0, busy=0.
- Handshake:
  - data_ready = reset & ~hold_full (combinational from registers only, never from data_valid).
  - A word is accepted at a rising edge when data_valid & data_ready.
  - data_in may change freely while data_valid is low.
- Acceptance routing, evaluated at the accepting edge:
  - Load the word directly into shift_reg (bit_cnt=0, state=SHIFT) when either:
    - state==IDLE, or
    - state==SHIFT and bit_cnt==WIDTH-1 (last bit).
  - Otherwise load the word into hold_reg and set hold_full=1.
- SHIFT state, each edge:
  - If bit_cnt<WIDTH-1: shift_reg shifts left by one and bit_cnt increments.
  - If bit_cnt==WIDTH-1 (frame end), priority order:
    1. hold_full: shift_reg=hold_reg, hold_full=0, bit_cnt=0, stay in SHIFT.
    2. Else a word is accepted this edge: bypass load as above, stay in SHIFT.
    3. Else state=IDLE, bit_cnt=0.
- Outputs (all decoded from registers):
  - out_valid = (state==SHIFT).
  - out_bit = shift_reg[WIDTH-1] in SHIFT; IDLE_BIT in IDLE.
  - frame_done = SHIFT & (bit_cnt==WIDTH-1).
  - busy = (state==SHIFT) | hold_full.
- Latency: a word accepted at edge N drives its MSB in the cycle after edge N.
- Bit timing: bit k (k=0 is the MSB) appears k cycles later.
- Throughput: one word per WIDTH cycles, with no gap between frames when data_valid is sustained.
- Data_ready timing in back-to-back streaming:
  - The second word is accepted into hold during the first frame.
  - data_ready is then low until the hold register transfers into shift_reg at the frame end.
- Simultaneous events:
  - Acceptance at the frame end with hold empty uses the bypass load.
  - Acceptance with hold full cannot occur, because data_ready is low.

Optional Feature:
- Macro: SER_PARITY_EN
- Defined:
  - Each frame is WIDTH+1 bits.
  - After the data LSB, one even-parity bit is sent, equal to the XOR of the word's bits.
  - bit_cnt counts to WIDTH; frame_done is asserted during the parity bit.
  - The parity value is computed at load time and held in a register.
- Undefined: frames are exactly WIDTH bits; no parity logic is synthesised.

Test Plan:
- Reset then release:
  - data_ready=0 during reset, then 1 in the first cycle after release.
  - out_valid=0, out_bit=0, busy=0, frame_done=0 throughout.
- Single word 8'hD0 accepted in cycle 0:
  - out_valid=1 for cycles 1-8, out_bit sequence 1,1,0,1,0,0,0,0.
  - frame_done=1 only in cycle 8; out_valid=0 and busy=0 in cycle 9.
- Back-to-back 8'hD0 (cycle 0) then 8'hDD (cycle 1), data_valid held:
  - 16 contiguous out_valid cycles (1-16) with no bubble.
  - data_ready=0 in cycles 2-8, then 1 in cycle 9.
  - frame_done=1 in cycles 8 and 16.
- Backpressure, third word 8'hA5 presented from cycle 2:
  - Not accepted until cycle 9, when it goes to hold.
  - Its MSB appears in cycle 17; out_bit for cycles 17-24 is 1,0,1,0,0,1,0,1.
- Reset pulled low in cycle 4 of a frame with a word held:
  - Next cycle: out_valid=0, busy=0, no frame_done.
  - A new word 8'hD0 afterwards serializes correctly, starting one cycle after acceptance.
- With SER_PARITY_EN defined, word 8'hD0:
  - 9 output bits 1,1,0,1,0,0,0,0,1.
  - frame_done only on the 9th bit.

Source files
------------

// File: rtl/ser_frame_tx.sv
// ser_frame_tx: MSB-first parallel-to-serial framer with a one-word hold register; `define SER_PARITY_EN appends an even-parity bit
module ser_frame_tx #(
    parameter int   WIDTH    = 8,
    parameter logic IDLE_BIT = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             data_valid,
    output logic             data_ready,
    output logic             out_bit,
    output logic             out_valid,
    output logic             frame_done,
    output logic             busy
);
    localparam int CW = $clog2(WIDTH + 1);
`ifdef SER_PARITY_EN
    localparam logic [CW-1:0] LAST = CW'(WIDTH);
`else
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
`endif

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] shift_reg, shift_n, hold_reg, hold_n;
    logic [CW-1:0]    bit_cnt, cnt_n;
    logic             hold_full, full_n, accept, last;
`ifdef SER_PARITY_EN
    logic             par_reg, par_n;
`endif

    assign data_ready = reset & ~hold_full;
    assign accept     = data_valid & data_ready;
    assign last       = (state == SHIFT) && (bit_cnt == LAST);
    assign out_valid  = (state == SHIFT);
    assign frame_done = last;
    assign busy       = (state == SHIFT) | hold_full;
`ifdef SER_PARITY_EN
    assign out_bit    = (state == SHIFT) ? (last ? par_reg : shift_reg[WIDTH-1]) : IDLE_BIT;
`else
    assign out_bit    = (state == SHIFT) ? shift_reg[WIDTH-1] : IDLE_BIT;
`endif

    // Next state: shift within a frame, chain held or bypassed words at the frame end
    always_comb begin
        state_n = state;
        shift_n = shift_reg;
        hold_n  = hold_reg;
        cnt_n   = bit_cnt;
        full_n  = hold_full;
`ifdef SER_PARITY_EN
        par_n   = par_reg;
`endif
        if (state == SHIFT) begin
            if (!last) begin
                shift_n = {shift_reg[WIDTH-2:0], 1'b0};
                cnt_n   = bit_cnt + CW'(1);
            end else if (hold_full) begin
                shift_n = hold_reg;
                full_n  = 1'b0;
                cnt_n   = '0;
`ifdef SER_PARITY_EN
                par_n   = ^hold_reg;
`endif
            end else begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        end
        if (accept) begin
            if (state == IDLE || last) begin
                shift_n = data_in;
                cnt_n   = '0;
                state_n = SHIFT;
`ifdef SER_PARITY_EN
                par_n   = ^data_in;
`endif
            end else begin
                hold_n = data_in;
                full_n = 1'b1;
            end
        end
    end

    // State register; reset drops any in-flight or held word
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            shift_reg <= '0;
            hold_reg  <= '0;
            bit_cnt   <= '0;
            hold_full <= 1'b0;
`ifdef SER_PARITY_EN
            par_reg   <= 1'b0;
`endif
        end else begin
            state     <= state_n;
            shift_reg <= shift_n;
            hold_reg  <= hold_n;
            bit_cnt   <= cnt_n;
            hold_full <= full_n;
`ifdef SER_PARITY_EN
            par_reg   <= par_n;
`endif
        end
    end
endmodule

// File: tb/tb_ser_frame_tx.sv
// tb_ser_frame_tx: randomized and directed checks of ser_frame_tx against a frame-queue reference model
module tb_ser_frame_tx;
    localparam int WIDTH = 8;
`ifdef SER_PARITY_EN
    localparam int FLEN = WIDTH + 1;
`else
    localparam int FLEN = WIDTH;
`endif

    logic clk = 1'b0, reset = 1'b0, data_valid = 1'b0;
    logic [WIDTH-1:0] data_in = '0;
    logic data_ready, out_bit, out_valid, frame_done, busy;
    logic [4:0] obs;
    int checks = 0, errors = 0;

    // Reference model: words accepted but not yet fully sent; head is the frame on the wire
    logic [WIDTH-1:0] mq[$];
    int pos = 0;
    bit acc;

    assign obs = {data_ready, out_valid, out_bit, frame_done, busy};

    always #5 clk = ~clk;

    ser_frame_tx #(.WIDTH(WIDTH), .IDLE_BIT(1'b0)) dut (
        .clk(clk), .reset(reset), .data_in(data_in), .data_valid(data_valid),
        .data_ready(data_ready), .out_bit(out_bit), .out_valid(out_valid),
        .frame_done(frame_done), .busy(busy)
    );

    function automatic logic [4:0] exp_vec();
        logic [WIDTH-1:0] w;
        logic b;
        if (mq.size() == 0) return {reset, 4'b0000};
        w = mq[0];
        b = (pos < WIDTH) ? w[WIDTH-1-pos] : ^w;
        return {reset && (mq.size() < 2), 1'b1, b, pos == FLEN - 1, 1'b1};
    endfunction

    task automatic tick();
        acc = data_valid && reset && (mq.size() < 2);
        @(posedge clk);
        if (!reset) begin
            mq.delete();
            pos = 0;
        end else begin
            if (mq.size() > 0) begin
                pos++;
                if (pos == FLEN) begin
                    void'(mq.pop_front());
                    pos = 0;
                end
            end
            if (acc) mq.push_back(data_in);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        data_valid = 1'b1;
        data_in = WIDTH'($urandom);
        repeat (3) tick();
        #1;
        checks++;
        if (obs !== 5'b00000) begin errors++; $display("FAIL reset_low: got %b expected %b", obs, 5'b00000); end
        reset = 1'b1;
        data_valid = 1'b0;
        #1;
        checks++;
        if (obs !== 5'b10000) begin errors++; $display("FAIL reset_release: got %b expected %b", obs, 5'b10000); end
        tick();
        #1;
        checks++;
        if (obs !== exp_vec()) begin errors++; $display("FAIL reset_idle: got %b expected %b", obs, exp_vec()); end
    endtask

    task automatic test_single();
        logic [63:0] bits = '0;
        logic [8:0] ep;
        int nb = 0, done_at = -1;
`ifdef SER_PARITY_EN
        ep = 9'b1_1010_0001;
`else
        ep = 9'h0D0;
`endif
        for (int c = 0; c <= FLEN + 1; c++) begin
            data_valid = (c == 0);
            data_in = (c == 0) ? WIDTH'(8'hD0) : WIDTH'($urandom);
            #1;
            checks++;
            if (obs !== exp_vec()) begin errors++; $display("FAIL single cyc %0d: got %b expected %b", c, obs, exp_vec()); end
            if (out_valid) begin bits = {bits[62:0], out_bit}; nb++; end
            if (frame_done) done_at = c;
            tick();
        end
        checks++;
        if (nb !== FLEN) begin errors++; $display("FAIL single_len: got %0d expected %0d", nb, FLEN); end
        checks++;
        if (bits[8:0] !== ep) begin errors++; $display("FAIL single_bits: got %b expected %b", bits[8:0], ep); end
        checks++;
        if (done_at !== FLEN) begin errors++; $display("FAIL single_done: got %0d expected %0d", done_at, FLEN); end
    endtask

    task automatic test_back_to_back();
        int a5_at = -1, rdy_low = 0, done_cnt = 0, valid_cnt = 0;
        for (int c = 0; c <= 3 * FLEN + 2; c++) begin
            data_valid = (c <= 1) || (a5_at < 0);
            data_in = (c == 0) ? WIDTH'(8'hD0) : (c == 1) ? WIDTH'(8'hDD) : WIDTH'(8'hA5);
            if (!data_valid) data_in = WIDTH'($urandom);
            #1;
            checks++;
            if (obs !== exp_vec()) begin errors++; $display("FAIL b2b cyc %0d: got %b expected %b", c, obs, exp_vec()); end
            if (c >= 2 && c <= FLEN && !data_ready) rdy_low++;
            if (frame_done) done_cnt++;
            if (c >= 1 && c <= 3 * FLEN && out_valid) valid_cnt++;
            tick();
            if (c >= 2 && acc && a5_at < 0) a5_at = c;
        end
        checks++;
        if (a5_at !== FLEN + 1) begin errors++; $display("FAIL b2b_a5_accept: got %0d expected %0d", a5_at, FLEN + 1); end
        checks++;
        if (rdy_low !== FLEN - 1) begin errors++; $display("FAIL b2b_ready_low: got %0d expected %0d", rdy_low, FLEN - 1); end
        checks++;
        if (done_cnt !== 3) begin errors++; $display("FAIL b2b_done_count: got %0d expected 3", done_cnt); end
        checks++;
        if (valid_cnt !== 3 * FLEN) begin errors++; $display("FAIL b2b_contiguous: got %0d expected %0d", valid_cnt, 3 * FLEN); end
    endtask

    task automatic test_reset_midframe();
        int done_at = -1;
        for (int c = 0; c <= FLEN + 7; c++) begin
            reset = (c != 4);
            data_valid = (c <= 1) || (c == 5);
            data_in = (c == 1) ? WIDTH'(8'hDD) : (c == 0 || c == 5) ? WIDTH'(8'hD0) : WIDTH'($urandom);
            #1;
            checks++;
            if (obs !== exp_vec()) begin errors++; $display("FAIL rst_mid cyc %0d: got %b expected %b", c, obs, exp_vec()); end
            if (c == 5) begin
                checks++;
                if ({out_valid, busy, frame_done} !== 3'b000) begin
                    errors++; $display("FAIL rst_mid_clear: got %b expected 000", {out_valid, busy, frame_done});
                end
            end
            if (c >= 5 && frame_done) done_at = c;
            tick();
        end
        checks++;
        if (done_at !== 5 + FLEN) begin errors++; $display("FAIL rst_mid_restart: got %0d expected %0d", done_at, 5 + FLEN); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom_range(0, 99) != 0);
            data_valid = ($urandom_range(0, 3) != 0);
            data_in = WIDTH'($urandom);
            #1;
            checks++;
            if (obs !== exp_vec()) begin errors++; $display("FAIL random cyc %0d: got %b expected %b", c, obs, exp_vec()); end
            tick();
        end
        reset = 1'b1;
        data_valid = 1'b0;
        for (int c = 0; c < 2 * FLEN + 2; c++) begin
            #1;
            checks++;
            if (obs !== exp_vec()) begin errors++; $display("FAIL drain cyc %0d: got %b expected %b", c, obs, exp_vec()); end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_reset_midframe();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
